// File: rtl/parity_serial_tx.sv
// Serial transmitter for the nibble parity link: accepts a word on valid/ready,
// then drives start, data (LSB first), parity and stop bits onto tx_out.
module parity_serial_tx #(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              parity_out,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        state_dbg
);

    // Handshake: a word is taken on a rising edge where valid_in & ready_out;
    // ready_out is high only in IDLE, so valid_in during a frame is ignored.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int TW = $clog2(BIT_CYCLES) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    state_t            state;
    logic [TW-1:0]     timer;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg;

    logic              bit_end;
    logic              par_calc;
    logic [DATA_W-1:0] sh_next;
    logic [TW-1:0]     timer_inc;

    always_comb begin
        bit_end   = (timer == T_LAST);
        par_calc  = (ODD_PARITY != 0) ? ~(^data_in) : (^data_in);
        sh_next   = shreg >> 1;
        timer_inc = timer + TW'(1);
    end

    assign state_dbg = state;

    // Every output is registered, so each branch loads the value the line
    // must carry during the cycle that follows the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            tx_out     <= 1'b1;
            ready_out  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            parity_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out     <= 1'b1;
                    ready_out  <= 1'b1;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                    timer      <= '0;
                    bitcnt     <= '0;
                    if (valid_in) begin
                        shreg      <= data_in;
                        parity_out <= par_calc;
                        state      <= START;
                        tx_out     <= 1'b0;
                        ready_out  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer  <= '0;
                        bitcnt <= '0;
                        state  <= DATA;
                        tx_out <= shreg[0];
                    end else begin
                        timer <= timer_inc;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bitcnt == B_LAST) begin
                            state  <= PARITY;
                            tx_out <= parity_out;
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            shreg  <= sh_next;
                            tx_out <= sh_next[0];
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer      <= '0;
                        state      <= STOP;
                        tx_out     <= 1'b1;
                        frame_done <= (BIT_CYCLES == 1);
                    end else begin
                        timer <= timer_inc;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer      <= '0;
                        state      <= IDLE;
                        tx_out     <= 1'b1;
                        ready_out  <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        timer      <= timer_inc;
                        // Pulse lands on the last cycle of the stop bit.
                        frame_done <= (timer_inc == T_LAST);
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_out    <= 1'b1;
                    ready_out <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: default instance (even, 1 cycle/bit)
// and a slow odd-parity instance (3 cycles/bit).
module tb_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, tx_a, par_a, busy_a, fd_a;
    logic       ready_b, tx_b, par_b, busy_b, fd_b;
    logic [2:0] st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_serial_tx dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .tx_out(tx_a), .parity_out(par_a),
        .busy(busy_a), .frame_done(fd_a), .state_dbg(st_a)
    );

    parity_serial_tx #(.DATA_W(4), .ODD_PARITY(1), .BIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .tx_out(tx_b), .parity_out(par_b),
        .busy(busy_b), .frame_done(fd_b), .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one word on dut_a from an IDLE negedge and checks every line cycle.
    task automatic frame_a(input logic [3:0] d, input logic [6:0] exp_line,
                           input string tag, output logic [6:0] line);
        chk({tag, " ready_before"}, ready_a, 1);
        data_a  = d;
        valid_a = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) begin
                valid_a = 1'b0;
                data_a  = ~d;
            end
            line[7-i] = tx_a;
            chk({tag, " busy"}, busy_a, 1);
            chk({tag, " frame_done"}, fd_a, (i == 7));
        end
        chk({tag, " line"}, line, exp_line);
        chk({tag, " parity_out"}, par_a, exp_line[1]);
        @(negedge clk);
        chk({tag, " idle_tx"}, tx_a, 1);
        chk({tag, " idle_busy"}, busy_a, 0);
        chk({tag, " idle_ready"}, ready_a, 1);
        chk({tag, " idle_fd"}, fd_a, 0);
    endtask

    initial begin
        logic [6:0] line, line_a, exp;
        logic [3:0] w;
        logic [3:0] samp;
        logic       p_samp;
        logic [6:0] pat_b;
        int         c, first, second;

        // T1: reset with valid_in asserted
        rst = 1'b1;
        valid_a = 1'b1; data_a = 4'hF;
        valid_b = 1'b1; data_b = 4'hF;
        repeat (2) @(negedge clk);
        chk("t1 tx", tx_a, 1);
        chk("t1 ready", ready_a, 1);
        chk("t1 busy", busy_a, 0);
        chk("t1 fd", fd_a, 0);
        chk("t1 parity", par_a, 0);
        chk("t1 state", st_a, 0);
        chk("t1 b_tx", tx_b, 1);
        chk("t1 b_ready", ready_b, 1);
        rst = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clk);

        // T2 / T3 directed frames
        frame_a(4'b1011, 7'b0110111, "t2", line);
        frame_a(4'b0000, 7'b0000001, "t3", line);

        // T3 loopback of all words into an even checker
        for (int k = 0; k < 16; k++) begin
            w = 4'(k);
            exp = {1'b0, w[0], w[1], w[2], w[3], ^w, 1'b1};
            frame_a(w, exp, $sformatf("loop%0d", k), line);
            chk($sformatf("loop%0d check", k), ^line[5:1], 0);
        end

        // T4: valid held high, data changed mid-frame
        data_a = 4'hA;
        valid_a = 1'b1;
        first = -1; second = -1; c = 0;
        while (c < 20) begin
            if (ready_a && valid_a) begin
                if (first < 0) first = c;
                else begin
                    second = c;
                    break;
                end
            end
            @(negedge clk);
            c++;
            if (c >= 1 && c <= 7) line_a[7-c] = tx_a;
            if (c == 1) data_a = 4'h5;
        end
        chk("t4 spacing", second - first, 8);
        chk("t4 line_a", line_a, 7'b0010101);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) valid_a = 1'b0;
            line[7-i] = tx_a;
        end
        chk("t4 line_5", line, 7'b0101001);
        @(negedge clk);
        chk("t4 idle", ready_a, 1);

        // T5: 3 cycles per bit, odd parity, data 0110
        pat_b = 7'b0011011;
        chk("t5 ready_before", ready_b, 1);
        data_b = 4'b0110;
        valid_b = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (i == 1) begin
                valid_b = 1'b0;
                data_b = 4'b1111;
            end
            chk($sformatf("t5 tx c%0d", i), tx_b, pat_b[6 - (i - 1) / 3]);
            chk($sformatf("t5 fd c%0d", i), fd_b, (i == 21));
            if (i == 5)  samp[0] = tx_b;
            if (i == 8)  samp[1] = tx_b;
            if (i == 11) samp[2] = tx_b;
            if (i == 14) samp[3] = tx_b;
            if (i == 17) p_samp = tx_b;
        end
        chk("t5 odd check", ^{samp, p_samp}, 1);
        chk("t5 parity_out", par_b, 1);
        @(negedge clk);
        chk("t5 idle_ready", ready_b, 1);
        chk("t5 idle_busy", busy_b, 0);

        // T6: reset during the DATA phase
        data_a = 4'b1011;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6 in_data", st_a, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 tx", tx_a, 1);
        chk("t6 ready", ready_a, 1);
        chk("t6 busy", busy_a, 0);
        chk("t6 fd", fd_a, 0);
        chk("t6 parity", par_a, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t6 quiet_fd %0d", i), fd_a, 0);
            chk($sformatf("t6 quiet_tx %0d", i), tx_a, 1);
        end
        frame_a(4'b1011, 7'b0110111, "t6 after", line);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
